// File: rtl/hi_lo_mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. It works on magnitudes one bit per cycle,
// applies the sign correction on the final step, and strobes HI/LO for one DONE cycle.
module hi_lo_mult_div_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_execute,
    input  logic [1:0]            operation_execute,
    input  logic [DATA_WIDTH-1:0] operand_A_execute,
    input  logic [DATA_WIDTH-1:0] operand_B_execute,
    input  logic                  using_HI_LO_execute,
    output logic                  busy,
    output logic                  stall_request,
    output logic [DATA_WIDTH-1:0] HI_result,
    output logic [DATA_WIDTH-1:0] LO_result,
    output logic                  HI_register_write,
    output logic                  LO_register_write
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MULTIPLY, DIVIDE, DONE} state_t;

    state_t                   state, next_state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [W-1:0]             acc_hi, acc_lo, operand_b;
    logic                     sign_a, sign_b, div_zero;

    logic                     last_iter;
    logic [W-1:0]             a_abs, b_abs;
    logic [W:0]               mul_sum, div_trial;
    logic [W-1:0]             step_hi, step_lo;
    logic [2*W-1:0]           product_fixed;
    logic [W-1:0]             quotient_fixed, remainder_fixed;
    logic                     sign_diff;

    assign last_iter         = (counter == COUNTER_WIDTH'(W - 1));
    assign busy              = (state != IDLE);
    assign stall_request     = busy && (start_execute || using_HI_LO_execute);
    assign HI_register_write = (state == DONE);
    assign LO_register_write = (state == DONE);

    // Signed ops work on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude.
    assign a_abs = (operation_execute[0] && operand_A_execute[W-1]) ? -operand_A_execute : operand_A_execute;
    assign b_abs = (operation_execute[0] && operand_B_execute[W-1]) ? -operand_B_execute : operand_B_execute;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_execute) next_state = operation_execute[1] ? DIVIDE : MULTIPLY;
            MULTIPLY: if (last_iter) next_state = DONE;
            DIVIDE:   if (last_iter) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // One iteration: shift-add multiply on {acc_hi, acc_lo}, or restoring divide
    // with acc_hi as the partial remainder and acc_lo shifting dividend out / quotient in.
    always_comb begin
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
        div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, operand_b};
        if (state == MULTIPLY) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo[W-1:1]};
        end else if (state == DIVIDE) begin
            if (!div_trial[W]) begin
                step_hi = div_trial[W-1:0];
                step_lo = {acc_lo[W-2:0], 1'b1};
            end else begin
                step_hi = {acc_hi[W-2:0], acc_lo[W-1]};
                step_lo = {acc_lo[W-2:0], 1'b0};
            end
        end
    end

    // On divide-by-zero the remainder is |A|; negating it when A was negative
    // restores the original operand, so only the quotient needs the override.
    assign sign_diff       = sign_a ^ sign_b;
    assign product_fixed   = sign_diff ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quotient_fixed  = (sign_diff && !div_zero) ? -step_lo : step_lo;
    assign remainder_fixed = sign_a ? -step_hi : step_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            HI_result <= '0;
            LO_result <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start_execute) begin
                        counter   <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= a_abs;
                        operand_b <= b_abs;
                        sign_a    <= operation_execute[0] & operand_A_execute[W-1];
                        sign_b    <= operation_execute[0] & operand_B_execute[W-1];
                        div_zero  <= (operand_B_execute == '0);
                    end
                end
                MULTIPLY, DIVIDE: begin
                    acc_hi  <= step_hi;
                    acc_lo  <= step_lo;
                    counter <= counter + 1'b1;
                    if (last_iter) begin
                        if (state == MULTIPLY) begin
                            {HI_result, LO_result} <= product_fixed;
                        end else begin
                            HI_result <= remainder_fixed;
                            LO_result <= quotient_fixed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
